// File: rtl/i2c_controller.sv
// Single-master I2C controller: one-byte write or read transaction per command.
// A command (7-bit address, R/W, write byte) is accepted over a valid/ready
// handshake. START, address, ACK, data, ACK and STOP are then sequenced on
// open-drain pad enables, and a one-cycle response pulse follows.
//
// Handshake: a command transfers on the cycle cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE. The response has no backpressure:
// rsp_valid is a single-cycle pulse, and rsp_rdata/rsp_nack hold their
// values until the next accepted command clears them.
//
// Optional build macro: I2C_CLK_STRETCH_EN enables clock stretching. When it
// is defined, the quarter counter freezes while a peripheral holds SCL low
// after the controller has released it.
module i2c_controller #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, RESP
    } state_t;

    localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

    state_t      state, next_state;
    logic [15:0] qcnt;
    logic [1:0]  phase;
    logic [2:0]  bitcnt;
    logic [7:0]  addr_byte;   // {addr, rw}; bit 0 selects read
    logic [7:0]  wdata_q;
    logic [7:0]  rx;
    logic        nack;
    logic        sda_s1, sda_s2;
    logic        accept;
    logic        freeze, tick, q_wrap, frame_end, sample;

    assign accept    = cmd_valid && cmd_ready;
    assign q_wrap    = (qcnt == QMAX);
    assign tick      = !freeze;
    assign frame_end = tick && q_wrap && (phase == 2'd3);
    // Sampled once, when the counter leaves the first cycle of phase 3.
    assign sample    = tick && (qcnt == 16'd0) && (phase == 2'd3);

`ifdef I2C_CLK_STRETCH_EN
    logic scl_s1, scl_s2;
    logic stretch_zone;

    // Synchronize the SCL pad level; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
        end
    end

    // SCL is always released inside these windows, so a low pad here
    // can only come from a peripheral holding the clock.
    assign stretch_zone = (((state == ADDR) || (state == ADDR_ACK) ||
                            (state == DATA) || (state == DATA_ACK)) && phase[1]) ||
                          ((state == STOP) && (phase == 2'd1));
    assign freeze = stretch_zone && !scl_s2;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign freeze       = 1'b0;
`endif

    // Two-flop synchronizer for the SDA pad level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Quarter/phase/bit timing; held at zero outside the bus sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qcnt   <= '0;
            phase  <= '0;
            bitcnt <= '0;
        end else if ((state == IDLE) || (state == RESP)) begin
            qcnt   <= '0;
            phase  <= '0;
            bitcnt <= '0;
        end else if (tick) begin
            if (q_wrap) begin
                qcnt  <= '0;
                phase <= phase + 2'd1;
                if ((phase == 2'd3) && ((state == ADDR) || (state == DATA)))
                    bitcnt <= bitcnt + 3'd1;
            end else begin
                qcnt <= qcnt + 16'd1;
            end
        end
    end

    // Command latch, ACK sampling and read-data shifting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_byte <= '0;
            wdata_q   <= '0;
            rx        <= '0;
            nack      <= 1'b0;
        end else if (accept) begin
            addr_byte <= {cmd_addr, cmd_rw};
            wdata_q   <= cmd_wdata;
            rx        <= '0;
            nack      <= 1'b0;
        end else if (sample) begin
            case (state)
                ADDR_ACK: nack <= sda_s2;
                DATA:     if (addr_byte[0]) rx <= {rx[6:0], sda_s2};
                DATA_ACK: if (!addr_byte[0]) nack <= sda_s2;
                default:  ;
            endcase
        end
    end

    // Next-state and pad-enable decode.
    always_comb begin
        next_state = state;
        scl_oe     = 1'b0;
        sda_oe     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) next_state = START;
            end
            START: begin
                sda_oe = phase[1];
                scl_oe = (phase == 2'd3);
                if (frame_end) next_state = ADDR;
            end
            ADDR: begin
                scl_oe = !phase[1];
                sda_oe = !addr_byte[3'd7 - bitcnt];
                if (frame_end && (bitcnt == 3'd7)) next_state = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_oe = !phase[1];
                if (frame_end) next_state = nack ? STOP : DATA;
            end
            DATA: begin
                scl_oe = !phase[1];
                sda_oe = !addr_byte[0] && !wdata_q[3'd7 - bitcnt];
                if (frame_end && (bitcnt == 3'd7)) next_state = DATA_ACK;
            end
            DATA_ACK: begin
                // Released for both directions: peripheral ACK on write,
                // master NACK ending the single-byte read.
                scl_oe = !phase[1];
                if (frame_end) next_state = STOP;
            end
            STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = !phase[1];
                if (frame_end) next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rx;
    assign rsp_nack  = nack;

endmodule

// File: tb/tb_i2c_controller.sv
// Testbench for i2c_controller with CLK_DIV=4 and a cycle-based peripheral model.
module tb_i2c_controller;

    localparam int CLK_DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
    // The synchronized SCL lags each release by two cycles, which freezes
    // the counter briefly at every release point (18 bit frames + STOP).
    localparam int LAT_FULL      = 80 * CLK_DIV + 1 + 2 * 19;
    localparam int LAT_NACK      = 44 * CLK_DIV + 1 + 2 * 10;
    localparam int STRETCH_DELTA = 20;
`else
    localparam int LAT_FULL      = 80 * CLK_DIV + 1;
    localparam int LAT_NACK      = 44 * CLK_DIV + 1;
    localparam int STRETCH_DELTA = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       scl_oe, sda_oe;
    logic       scl_pad, sda_pad;
    logic       m_sda_low = 1'b0;
    logic       m_scl_low = 1'b0;

    // Open-drain bus with pull-ups.
    assign scl_pad = !scl_oe && !m_scl_low;
    assign sda_pad = !sda_oe && !m_sda_low;

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_i(scl_pad), .sda_i(sda_pad)
    );

    // ---------------- peripheral model ----------------
    logic        m_ack_addr = 1'b0, m_ack_data = 1'b0, m_stretch = 1'b0;
    logic [7:0]  m_rdata = '0;
    logic        m_prev_oe = 1'b0, m_prev_scl = 1'b1, m_prev_sda = 1'b1;
    logic        m_started = 1'b0, m_stop = 1'b0, m_st_done = 1'b0, m_rw = 1'b0;
    int          m_cnt = 0, m_st_cnt = 0;
    logic [31:0] m_wire = '0;

    // Bit clock follows the controller's SCL release/grab; bus levels are
    // recorded at each release, and the model drives SDA right after a grab.
    always @(negedge clk) begin
        if (!rst) begin
            m_sda_low  <= 1'b0;
            m_scl_low  <= 1'b0;
            m_started  = 1'b0;
            m_stop     = 1'b0;
            m_cnt      = 0;
            m_st_cnt   = 0;
            m_prev_oe  = 1'b0;
            m_prev_scl = 1'b1;
            m_prev_sda = 1'b1;
        end else begin
            if (m_prev_scl && scl_pad && m_prev_sda && !sda_pad) begin
                m_started = 1'b1;
                m_cnt     = 0;
                m_wire    = '0;
                m_stop    = 1'b0;
                m_st_done = 1'b0;
            end else if (m_started && m_prev_scl && scl_pad && !m_prev_sda && sda_pad) begin
                m_stop = 1'b1;
            end
            if (m_st_cnt > 0) begin
                m_st_cnt = m_st_cnt - 1;
                if (m_st_cnt == 0) m_scl_low <= 1'b0;
            end
            if (m_started && m_prev_oe && !scl_oe) begin
                if (m_stretch && !m_st_done && (m_cnt == 0)) begin
                    m_scl_low <= 1'b1;
                    m_st_cnt  = 20;
                    m_st_done = 1'b1;
                end
                m_wire = {m_wire[30:0], sda_pad};
                m_cnt  = m_cnt + 1;
                if (m_cnt == 8) m_rw = sda_pad;
            end
            if (m_started && !m_prev_oe && scl_oe) begin
                if (m_cnt == 8)
                    m_sda_low <= m_ack_addr;
                else if ((m_cnt >= 9) && (m_cnt <= 16))
                    m_sda_low <= m_rw && m_ack_addr && !m_rdata[3'(16 - m_cnt)];
                else if (m_cnt == 17)
                    m_sda_low <= !m_rw && m_ack_data;
                else
                    m_sda_low <= 1'b0;
            end
            m_prev_oe  = scl_oe;
            m_prev_scl = scl_pad;
            m_prev_sda = sda_pad;
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass = 0;
    int n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                           input logic exp_nack, input logic [7:0] exp_rdata,
                           output int lat);
        int k;
        @(negedge clk);
        check("ready_before", 32'(cmd_ready), 1);
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        k = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            if (i == 10) begin
                check("busy_mid", 32'(busy), 1);
                check("ready_mid", 32'(cmd_ready), 0);
            end
            if (rsp_valid) begin
                lat = cyc - k;
                check("rsp_nack", 32'(rsp_nack), 32'(exp_nack));
                check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("rsp_timeout", 0, 1);
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 0);
        check("ready_after", 32'(cmd_ready), 1);
        check("nack_hold", 32'(rsp_nack), 32'(exp_nack));
        check("rdata_hold", 32'(rsp_rdata), 32'(exp_rdata));
    endtask

    task automatic set_model(input logic aa, input logic ad, input logic [7:0] rd,
                             input logic st);
        m_ack_addr = aa;
        m_ack_data = ad;
        m_rdata    = rd;
        m_stretch  = st;
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        ack_addr;
        logic        ack_data;
        logic [7:0]  sdata;
        int          exp_lat;
        logic        exp_nack;
        logic [7:0]  exp_rdata;
        int          exp_edges;
        logic [18:0] exp_wire;   // bus bits at each SCL release, last one is STOP
    } vec_t;

    vec_t vecs[4];
    int   lat, lat0, lat1;

    initial begin
        // write 0x50 <- 0xA5, both ACKed
        vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, LAT_FULL, 1'b0, 8'h00, 19,
                    19'b10100000_0_10100101_0_0};
        // write to silent address 0x22: address NACK, no data bits
        vecs[1] = '{7'h22, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, LAT_NACK, 1'b1, 8'h00, 10,
                    19'b01000100_1_0};
        // read 0x3C, peripheral returns 0x5E, master NACKs
        vecs[2] = '{7'h3C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5E, LAT_FULL, 1'b0, 8'h5E, 19,
                    19'b01111001_0_01011110_1_0};
        // write 0x11 <- 0x0F, data byte NACKed
        vecs[3] = '{7'h11, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00, LAT_FULL, 1'b1, 8'h00, 19,
                    19'b00100010_0_00001111_1_0};

        // reset hold and release
        repeat (3) @(negedge clk);
        check("rst_scl_oe", 32'(scl_oe), 0);
        check("rst_sda_oe", 32'(sda_oe), 0);
        rst = 1'b1;
        @(negedge clk);
        check("init_scl_oe", 32'(scl_oe), 0);
        check("init_sda_oe", 32'(sda_oe), 0);
        check("init_ready", 32'(cmd_ready), 1);
        check("init_busy", 32'(busy), 0);
        check("init_rsp_valid", 32'(rsp_valid), 0);
        check("init_rdata", 32'(rsp_rdata), 0);
        check("init_nack", 32'(rsp_nack), 0);

        // table-driven transactions
        for (int v = 0; v < 4; v++) begin
            set_model(vecs[v].ack_addr, vecs[v].ack_data, vecs[v].sdata, 1'b0);
            run_cmd(vecs[v].addr, vecs[v].rw, vecs[v].wdata,
                    vecs[v].exp_nack, vecs[v].exp_rdata, lat);
            check($sformatf("latency_v%0d", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("edges_v%0d", v), 32'(m_cnt), 32'(vecs[v].exp_edges));
            check($sformatf("wire_v%0d", v), m_wire, {13'b0, vecs[v].exp_wire});
            check($sformatf("stop_v%0d", v), 32'(m_stop), 1);
            if (v == 0) lat0 = lat;
        end

        // reset in the middle of DATA bit 3 (bit value 0, so SDA is driven)
        set_model(1'b1, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = 1'b0; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                #1;
                if ((m_cnt == 12) && !scl_pad) begin
                    found = 1'b1;
                    break;
                end
            end
            check("reach_data_bit3", 32'(found), 1);
        end
        check("pre_rst_scl_oe", 32'(scl_oe), 1);
        check("pre_rst_sda_oe", 32'(sda_oe), 1);
        rst = 1'b0;
        #1;
        check("abort_scl_oe", 32'(scl_oe), 0);
        check("abort_sda_oe", 32'(sda_oe), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_nack", 32'(rsp_nack), 0);
        run_cmd(vecs[0].addr, vecs[0].rw, vecs[0].wdata, 1'b0, 8'h00, lat);
        check("post_rst_latency", 32'(lat), 32'(LAT_FULL));
        check("post_rst_wire", m_wire, {13'b0, vecs[0].exp_wire});

        // peripheral holds SCL low for 20 cycles at ADDR bit 0
        set_model(1'b1, 1'b1, 8'h00, 1'b1);
        run_cmd(vecs[0].addr, vecs[0].rw, vecs[0].wdata, 1'b0, 8'h00, lat1);
        check("stretch_delta", 32'(lat1 - lat0), 32'(STRETCH_DELTA));
        check("stretch_stop", 32'(m_stop), 1);
        set_model(1'b1, 1'b1, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
